// File: rtl/ppm_frame_encoder.sv
// PPM frame encoder: valid/ready channel updates, frame-synchronous apply, registered PPM line.
// Optional failsafe (zero all channels after FAILSAFE_FRAMES idle frames) enabled by PPM_FAILSAFE_EN.

module ppm_ch_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd_en,
  input  logic       load_en,
  input  logic       zero_en,
  input  logic [7:0] din,
  output logic [7:0] act
);
  logic [7:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      act    <= '0;
    end else begin
      if (upd_en) shadow <= din;
      if (load_en)      act <= (shadow > 8'd250) ? 8'd250 : shadow;
      else if (zero_en) act <= '0;
    end
  end
endmodule

module ppm_frame_encoder #(
  parameter int TICK_DIV        = 50,
  parameter int NUM_CH          = 4,
  parameter int MARK_US         = 300,
  parameter int FRAME_US        = 20000,
  parameter int FAILSAFE_FRAMES = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                upd_valid,
  input  logic [8*NUM_CH-1:0] upd_data,
  output logic                upd_ready,
  output logic                ppm_out,
  output logic                frame_start,
  output logic                failsafe
);
  localparam int US_W = $clog2(FRAME_US + 1);
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_MARK, S_SPACE, S_SYNC_MARK, S_SYNC_SPACE} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            ch, ch_nxt;
  logic                     armed;
  logic [PW-1:0]            pre;
  logic [US_W-1:0]          slot_us, frame_us;
  logic                     pending;
  logic [NUM_CH-1:0][7:0]   act;
  logic                     acc, load_en, zero_en;
  logic                     tick, fs_now, mark_end, slot_end;
  logic [10:0]              slot_len;
  logic                     ppm_d;

  assign upd_ready = !pending;
  assign acc       = upd_valid && !pending;
  assign load_en   = frame_start && pending;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ppm_ch_reg u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .upd_en  (acc),
      .load_en (load_en),
      .zero_en (zero_en),
      .din     (upd_data[8*g +: 8]),
      .act     (act[g])
    );
  end

  assign slot_len = 11'd1000 + {1'b0, act[ch], 2'b00};
  assign tick     = (pre == PW'(TICK_DIV - 1));
  assign mark_end = tick && (slot_us == US_W'(MARK_US - 1));
  assign slot_end = tick && (slot_us == US_W'(slot_len - 11'd1));
  // armed is low only for the first cycle out of reset, which starts frame 0
  assign fs_now   = !armed ||
                    (state == S_SYNC_SPACE && tick && frame_us == US_W'(FRAME_US - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_MARK;
      ch    <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    if (fs_now) begin
      state_nxt = S_MARK;
      ch_nxt    = '0;
    end else begin
      case (state)
        S_MARK:      if (mark_end) state_nxt = S_SPACE;
        S_SPACE:     if (slot_end) begin
                       if (ch == CW'(NUM_CH - 1)) state_nxt = S_SYNC_MARK;
                       else begin
                         state_nxt = S_MARK;
                         ch_nxt    = ch + 1'b1;
                       end
                     end
        S_SYNC_MARK: if (mark_end) state_nxt = S_SYNC_SPACE;
        default:     state_nxt = state;
      endcase
    end
  end

  always_comb begin
    ppm_d = !(state_nxt == S_MARK || state_nxt == S_SYNC_MARK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppm_out     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      ppm_out     <= ppm_d;
      frame_start <= fs_now;
    end
  end

  // Slot counter spans mark+space of one slot; frame counter spans the whole frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre      <= '0;
      slot_us  <= '0;
      frame_us <= '0;
    end else if (fs_now) begin
      pre      <= '0;
      slot_us  <= '0;
      frame_us <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        frame_us <= frame_us + 1'b1;
        slot_us  <= (state == S_SPACE && slot_end) ? '0 : slot_us + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pending <= 1'b0;
    else if (acc)         pending <= 1'b1;
    else if (frame_start) pending <= 1'b0;
  end

`ifdef PPM_FAILSAFE_EN
  localparam int FW = $clog2(FAILSAFE_FRAMES + 1);
  logic [FW-1:0] fcnt;
  logic          fs_q;

  assign failsafe = fs_q;
  assign zero_en  = frame_start && !acc && !pending && !fs_q &&
                    (fcnt >= FW'(FAILSAFE_FRAMES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
      fs_q <= 1'b0;
    end else if (acc) begin
      fcnt <= '0;
      fs_q <= 1'b0;
    end else if (frame_start && !fs_q) begin
      fcnt <= fcnt + 1'b1;
      if (zero_en) fs_q <= 1'b1;
    end
  end
`else
  assign failsafe = 1'b0;
  assign zero_en  = 1'b0;
`endif

endmodule

// File: tb/tb_ppm_frame_encoder.sv
// Directed bench for ppm_frame_encoder: measures every low/high run of whole frames
// and compares them with slot lengths computed from the channel values.

module tb_ppm_frame_encoder;
  localparam int NC = 2;
  localparam int TD = 2;
  localparam int MK = 30;
  localparam int FR = 4200;
`ifdef PPM_FAILSAFE_EN
  localparam int FSF = 3;
`else
  localparam int FSF = 50;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            upd_valid = 1'b0;
  logic [8*NC-1:0] upd_data = '0;
  logic            upd_ready, ppm_out, frame_start, failsafe;

  int n_chk = 0;
  int n_pass = 0;
  int runs[16];
  int nruns;
  int frame_len;

  always #5 clk = ~clk;

  ppm_frame_encoder #(
    .TICK_DIV(TD), .NUM_CH(NC), .MARK_US(MK), .FRAME_US(FR), .FAILSAFE_FRAMES(FSF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_data(upd_data),
    .upd_ready(upd_ready), .ppm_out(ppm_out), .frame_start(frame_start), .failsafe(failsafe)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int slot_cyc(input int v);
    int c;
    c = (v > 250) ? 250 : v;
    return (1000 + 4 * c) * TD;
  endfunction

  // Entered at the negedge of a frame_start cycle; returns at the next one.
  task automatic measure();
    logic prev;
    int   len;
    bit   got;
    got = 1'b0;
    nruns = 0;
    frame_len = 1;
    len = 1;
    prev = ppm_out;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (frame_start) begin
        got = 1'b1;
        break;
      end
      frame_len++;
      if (ppm_out !== prev) begin
        if (nruns < 16) runs[nruns] = len;
        nruns++;
        len = 1;
        prev = ppm_out;
      end else len++;
    end
    if (nruns < 16) runs[nruns] = len;
    nruns++;
    if (!got) chk("frame_start_timeout", 0, 1);
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    chk("frame_start_timeout", 0, 1);
  endtask

  task automatic check_frame(input string tag, input int v0, input int v1);
    int s0, s1;
    s0 = slot_cyc(v0);
    s1 = slot_cyc(v1);
    chk({tag, ".runs"},   nruns, 2 * (NC + 1));
    chk({tag, ".mark0"},  runs[0], MK * TD);
    chk({tag, ".slot0"},  runs[0] + runs[1], s0);
    chk({tag, ".mark1"},  runs[2], MK * TD);
    chk({tag, ".slot1"},  runs[2] + runs[3], s1);
    chk({tag, ".smark"},  runs[4], MK * TD);
    chk({tag, ".sspace"}, runs[5], FR * TD - s0 - s1 - MK * TD);
    chk({tag, ".frame"},  frame_len, FR * TD);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.ppm", ppm_out, 1);
    chk("rst.fs", frame_start, 0);
    chk("rst.rdy", upd_ready, 1);
    chk("rst.failsafe", failsafe, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first.fs", frame_start, 1);
    chk("first.ppm", ppm_out, 0);

    // Frame A: accept an update mid-frame, then hold a second one offered
    fork
      measure();
      begin
        repeat (100) @(negedge clk);
        chk("a.rdy_pre", upd_ready, 1);
        upd_data  = {8'd255, 8'd125};
        upd_valid = 1'b1;
        @(negedge clk);
        chk("a.rdy_acc", upd_ready, 0);
        upd_data = {8'd250, 8'd0};
        repeat (3000) @(negedge clk);
        chk("a.rdy_hold", upd_ready, 0);
      end
    join
    check_frame("a", 0, 0);
    chk("c.rdy_fs", upd_ready, 0);

    // Frame C: first update shows; second is taken the cycle after frame_start
    fork
      measure();
      begin
        @(negedge clk);
        chk("c.rdy_after_fs", upd_ready, 1);
        @(negedge clk);
        chk("c.rdy_taken", upd_ready, 0);
        upd_valid = 1'b0;
      end
    join
    check_frame("c", 125, 255);

    measure();
    check_frame("d", 0, 250);

    // Frame E: offer on the frame_start cycle; must not apply until frame F
    chk("e.rdy_fs", upd_ready, 1);
    upd_data  = {8'd10, 8'd100};
    upd_valid = 1'b1;
    fork
      measure();
      begin
        @(negedge clk);
        upd_valid = 1'b0;
        chk("e.rdy_taken", upd_ready, 0);
      end
    join
    check_frame("e", 0, 250);

    measure();
    check_frame("f", 100, 10);

    // Frame G: reset during channel 1's mark
    repeat (2820) @(negedge clk);
    chk("g.in_mark1", ppm_out, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("g.rst_ppm", ppm_out, 1);
    chk("g.rst_rdy", upd_ready, 1);
    @(negedge clk);
    chk("g.rst_fs", frame_start, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("h.fs", frame_start, 1);
    measure();
    check_frame("h", 0, 0);

`ifdef PPM_FAILSAFE_EN
    upd_data  = {8'd200, 8'd200};
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    wait_fs();
    @(negedge clk);
    chk("fs.after1", failsafe, 0);
    wait_fs();
    @(negedge clk);
    chk("fs.after2", failsafe, 0);
    wait_fs();
    fork
      measure();
      begin
        @(negedge clk);
        chk("fs.after3", failsafe, 1);
        repeat (200) @(negedge clk);
        upd_data  = {8'd50, 8'd20};
        upd_valid = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        chk("fs.cleared", failsafe, 0);
      end
    join
    check_frame("fs_l", 0, 0);
    measure();
    check_frame("fs_m", 20, 50);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
